// File: rtl/bus_xfer_sequencer_if.sv
// ----------------------------------------------------------------------------
// bus_xfer_sequencer_if
// Groups the request handshake and the bus-control outputs of the transfer
// sequencer.
//   master : requester side; drives req_valid/req_src/req_dst and observes
//            the rest.
//   slave  : sequencer side; accepts requests and drives req_ready,
//            bus_out_sel, load_en, busy, done and err.
// Signals:
//   req_valid / req_ready  : request handshake (accept on valid && ready)
//   req_src / req_dst      : 5-bit bus source / destination indices
//   bus_out_sel            : one-hot bus source select
//   load_en                : one-hot destination load enable
//   busy                   : transfer in flight or requests pending
//   done                   : one-cycle pulse per completed transfer
//   err                    : one-cycle pulse per rejected (out-of-range) request
// ----------------------------------------------------------------------------
interface bus_xfer_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [31:0] bus_out_sel;
  logic [31:0] load_en;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, bus_out_sel, load_en, busy, done, err
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, bus_out_sel, load_en, busy, done, err
  );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// bus_xfer_sequencer
// Sequences register transfers for the datapath bus multiplexer. Requests
// {src, dst} are buffered in a DEPTH-entry FIFO. Each transfer drives the
// one-hot source select for two cycles (DRIVE, LOAD) and pulses the one-hot
// destination load enable during the second cycle, so the destination
// captures a settled bus value on the edge that ends LOAD. Back-to-back
// transfers run at one per two cycles with no idle gap on the bus.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : bus_xfer_sequencer_if.slave (request handshake + bus controls)
// Parameters:
//   DEPTH : FIFO depth, power of two, >= 2
//   NSRC  : number of legal source/destination indices (0..NSRC-1)
// ----------------------------------------------------------------------------
module bus_xfer_sequencer #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 24
) (
  input  logic                  clock,
  input  logic                  clear,
  bus_xfer_sequencer_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  // One extra bit so an NSRC of 32 still compares correctly.
  localparam logic [5:0]    NSRC_LIM = 6'(NSRC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      mem_q [DEPTH];
  logic [9:0]      mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      cur_dst_q, cur_dst_d;
  logic [31:0]     bus_sel_q, bus_sel_d;
  logic [31:0]     load_en_q, load_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            ready_s;
  logic            accept_s;
  logic            idx_bad_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_nonempty_s;
  logic [4:0]      head_src_s;
  logic [4:0]      head_dst_s;

  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    onehot32 = 32'd1 << idx;
  endfunction

  // Handshake, index check and FIFO head decode.
  assign fifo_nonempty_s = (count_q != {CW{1'b0}});
  assign ready_s         = (count_q != FULL_CNT);
  assign accept_s        = bus.req_valid && ready_s;
  assign idx_bad_s       = ({1'b0, bus.req_src} >= NSRC_LIM) ||
                           ({1'b0, bus.req_dst} >= NSRC_LIM);
  // Out-of-range requests complete the handshake but are never queued.
  assign push_s          = accept_s && !idx_bad_s;
  assign head_src_s      = mem_q[rd_ptr_q][9:5];
  assign head_dst_s      = mem_q[rd_ptr_q][4:0];

  assign bus.req_ready   = ready_s;
  assign bus.bus_out_sel = bus_sel_q;
  assign bus.load_en     = load_en_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != ST_IDLE) || fifo_nonempty_s;

  // Transfer FSM next-state and next-output decode; also decides the pop.
  always_comb begin
    state_d   = state_q;
    bus_sel_d = bus_sel_q;
    load_en_d = 32'd0;
    cur_dst_d = cur_dst_q;
    done_d    = 1'b0;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty_s) begin
          pop_s     = 1'b1;
          bus_sel_d = onehot32(head_src_s);
          cur_dst_d = head_dst_s;
          state_d   = ST_DRIVE;
        end else begin
          bus_sel_d = 32'd0;
        end
      end
      ST_DRIVE: begin
        load_en_d = onehot32(cur_dst_q);
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        done_d = 1'b1;
        // Pop decision uses the registered count, so an entry pushed on
        // this same edge waits for the following edge.
        if (fifo_nonempty_s) begin
          pop_s     = 1'b1;
          bus_sel_d = onehot32(head_src_s);
          cur_dst_d = head_dst_s;
          state_d   = ST_DRIVE;
        end else begin
          bus_sel_d = 32'd0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        bus_sel_d = 32'd0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = accept_s && idx_bad_s;
    if (push_s) begin
      mem_d[wr_ptr_q] = {bus.req_src, bus.req_dst};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // All state; clear drops any in-flight transfer and its pending pulses.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 10'd0;
      end
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      cur_dst_q <= 5'd0;
      bus_sel_q <= 32'd0;
      load_en_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cur_dst_q <= cur_dst_d;
      bus_sel_q <= bus_sel_d;
      load_en_q <= load_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bus_xfer_sequencer
// Directed testbench for bus_xfer_sequencer: single transfer, back-to-back
// transfers, FIFO fill with backpressure, out-of-range requests, and
// asynchronous clear in the middle of a LOAD cycle.
// ----------------------------------------------------------------------------
module tb_bus_xfer_sequencer;

  logic clock;
  logic clear;
  int   total_cnt;
  int   bad_cnt;

  bus_xfer_sequencer_if bif ();

  bus_xfer_sequencer #(
    .DEPTH (4),
    .NSRC  (24)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bif.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One isolated transfer, accepted at edge k, checked through k+4.
  task automatic run_single(input string tag, input logic [4:0] s, input logic [4:0] d);
    logic [31:0] sv;
    logic [31:0] dv;
    sv = 32'd1 << s;
    dv = 32'd1 << d;
    chk({tag, "_ready"}, 32'(bif.req_ready), 32'd1);
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    tick();
    bif.req_valid = 1'b0;
    chk({tag, "_k_bus"},   bif.bus_out_sel, 32'd0);
    chk({tag, "_k_busy"},  32'(bif.busy), 32'd1);
    chk({tag, "_k_err"},   32'(bif.err), 32'd0);
    tick();
    chk({tag, "_k1_bus"},  bif.bus_out_sel, sv);
    chk({tag, "_k1_load"}, bif.load_en, 32'd0);
    tick();
    chk({tag, "_k2_bus"},  bif.bus_out_sel, sv);
    chk({tag, "_k2_load"}, bif.load_en, dv);
    chk({tag, "_k2_done"}, 32'(bif.done), 32'd0);
    tick();
    chk({tag, "_k3_bus"},  bif.bus_out_sel, 32'd0);
    chk({tag, "_k3_load"}, bif.load_en, 32'd0);
    chk({tag, "_k3_done"}, 32'(bif.done), 32'd1);
    chk({tag, "_k3_busy"}, 32'(bif.busy), 32'd0);
    tick();
    chk({tag, "_k4_done"}, 32'(bif.done), 32'd0);
  endtask

  // Three requests on consecutive edges; exact per-cycle bus/load/done.
  task automatic run_back_to_back();
    logic [31:0] exp_bus  [8];
    logic [31:0] exp_load [8];
    logic        exp_done [8];
    logic [4:0]  srcs [3];
    logic [4:0]  dsts [3];
    srcs[0] = 5'd21; dsts[0] = 5'd4;
    srcs[1] = 5'd20; dsts[1] = 5'd17;
    srcs[2] = 5'd23; dsts[2] = 5'd0;
    exp_bus[0] = 32'h0020_0000; exp_load[0] = 32'h0000_0000; exp_done[0] = 1'b0;
    exp_bus[1] = 32'h0020_0000; exp_load[1] = 32'h0000_0010; exp_done[1] = 1'b0;
    exp_bus[2] = 32'h0010_0000; exp_load[2] = 32'h0000_0000; exp_done[2] = 1'b1;
    exp_bus[3] = 32'h0010_0000; exp_load[3] = 32'h0002_0000; exp_done[3] = 1'b0;
    exp_bus[4] = 32'h0080_0000; exp_load[4] = 32'h0000_0000; exp_done[4] = 1'b1;
    exp_bus[5] = 32'h0080_0000; exp_load[5] = 32'h0000_0001; exp_done[5] = 1'b0;
    exp_bus[6] = 32'h0000_0000; exp_load[6] = 32'h0000_0000; exp_done[6] = 1'b1;
    exp_bus[7] = 32'h0000_0000; exp_load[7] = 32'h0000_0000; exp_done[7] = 1'b0;
    bif.req_valid = 1'b1;
    bif.req_src   = srcs[0];
    bif.req_dst   = dsts[0];
    tick();
    for (int n = 0; n < 8; n++) begin
      if (n < 2) begin
        bif.req_src = srcs[n + 1];
        bif.req_dst = dsts[n + 1];
      end else begin
        bif.req_valid = 1'b0;
      end
      tick();
      chk($sformatf("b2b_bus%0d", n),  bif.bus_out_sel, exp_bus[n]);
      chk($sformatf("b2b_load%0d", n), bif.load_en, exp_load[n]);
      chk($sformatf("b2b_done%0d", n), 32'(bif.done), 32'(exp_done[n]));
    end
    chk("b2b_busy_end", 32'(bif.busy), 32'd0);
  endtask

  // Offer a request on every cycle for 8 cycles, holding each until taken.
  task automatic run_fill();
    logic [4:0] qs [$];
    logic [4:0] qd [$];
    int         acc;
    int         done_cnt;
    int         ready_drop;
    int         nxt;
    logic       vld_b;
    logic       rdy_b;
    logic [4:0] es;
    logic [4:0] ed;
    acc = 0; done_cnt = 0; ready_drop = 0; nxt = 0;
    bif.req_valid = 1'b1;
    bif.req_src   = 5'(nxt);
    bif.req_dst   = 5'(nxt + 8);
    for (int c = 0; c < 40; c++) begin
      vld_b = bif.req_valid;
      rdy_b = bif.req_ready;
      tick();
      if (vld_b && rdy_b) begin
        qs.push_back(bif.req_src);
        qd.push_back(bif.req_dst);
        acc++;
        nxt++;
      end
      if (!bif.req_ready) ready_drop = 1;
      if (bif.done) done_cnt++;
      if (bif.load_en != 32'd0) begin
        if (qd.size() == 0) begin
          chk("fill_extra_load", bif.load_en, 32'd0);
        end else begin
          es = qs.pop_front();
          ed = qd.pop_front();
          chk("fill_load", bif.load_en, 32'd1 << ed);
          chk("fill_bus",  bif.bus_out_sel, 32'd1 << es);
        end
      end
      if (c < 7) begin
        bif.req_valid = 1'b1;
        bif.req_src   = 5'(nxt);
        bif.req_dst   = 5'(nxt + 8);
      end else begin
        bif.req_valid = 1'b0;
      end
    end
    chk("fill_accepted",  32'(acc), 32'd7);
    chk("fill_done_cnt",  32'(done_cnt), 32'd7);
    chk("fill_leftover",  32'(qd.size()), 32'd0);
    chk("fill_ready_drop", 32'(ready_drop), 32'd1);
    chk("fill_busy_end",  32'(bif.busy), 32'd0);
  endtask

  // Out-of-range request: consumed, err pulse, no bus activity.
  task automatic run_bad(input string tag, input logic [4:0] s, input logic [4:0] d);
    bif.req_valid = 1'b1;
    bif.req_src   = s;
    bif.req_dst   = d;
    tick();
    bif.req_valid = 1'b0;
    chk({tag, "_err"},  32'(bif.err), 32'd1);
    chk({tag, "_busy"}, 32'(bif.busy), 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk({tag, "_err_low"}, 32'(bif.err), 32'd0);
      chk({tag, "_bus"},     bif.bus_out_sel, 32'd0);
      chk({tag, "_load"},    bif.load_en, 32'd0);
    end
  endtask

  // Clear asserted during LOAD of the first of three queued transfers.
  task automatic run_clear_mid_load();
    bif.req_valid = 1'b1;
    bif.req_src = 5'd2; bif.req_dst = 5'd3;
    tick();
    bif.req_src = 5'd4; bif.req_dst = 5'd5;
    tick();
    bif.req_src = 5'd6; bif.req_dst = 5'd7;
    tick();
    bif.req_valid = 1'b0;
    chk("clr_in_load", bif.load_en, 32'h0000_0008);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_bus",   bif.bus_out_sel, 32'd0);
    chk("clr_load",  bif.load_en, 32'd0);
    chk("clr_done",  32'(bif.done), 32'd0);
    chk("clr_busy",  32'(bif.busy), 32'd0);
    chk("clr_ready", 32'(bif.req_ready), 32'd1);
    tick();
    chk("clr_done_hold", 32'(bif.done), 32'd0);
    clear = 1'b1;
    tick();
    chk("clr_post_busy", 32'(bif.busy), 32'd0);
    chk("clr_post_bus",  bif.bus_out_sel, 32'd0);
    chk("clr_post_done", 32'(bif.done), 32'd0);
    run_single("after_clr", 5'd0, 5'd1);
  endtask

  // Main sequence.
  initial begin
    total_cnt     = 0;
    bad_cnt       = 0;
    clear         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_src   = 5'd0;
    bif.req_dst   = 5'd0;
    #3;
    chk("rst_bus",   bif.bus_out_sel, 32'd0);
    chk("rst_load",  bif.load_en, 32'd0);
    chk("rst_done",  32'(bif.done), 32'd0);
    chk("rst_err",   32'(bif.err), 32'd0);
    chk("rst_busy",  32'(bif.busy), 32'd0);
    chk("rst_ready", 32'(bif.req_ready), 32'd1);
    tick();
    tick();
    clear = 1'b1;
    tick();

    run_single("single", 5'd3, 5'd7);
    run_single("same",   5'd23, 5'd23);
    run_back_to_back();
    run_fill();
    run_bad("bad_src", 5'd24, 5'd2);
    run_single("after_bad", 5'd5, 5'd6);
    run_bad("bad_dst", 5'd1, 5'd31);
    run_clear_mid_load();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/bus_xfer_sequencer.md
# bus_xfer_sequencer

Control-side sequencer that sits directly upstream of the datapath bus multiplexer. It accepts register-transfer requests (source index, destination index) through a valid/ready handshake and buffers them in a small FIFO. For each request it drives the bus's 32-bit one-hot source-select vector and then pulses the destination's one-hot load enable, so the destination captures the bus value on a clean edge. Transfers complete strictly in order, at one every two cycles.

## Interface
Parameters:
- DEPTH, 4 — request FIFO depth; must be a power of two, at least 2.
- NSRC, 24 — number of valid source/destination indices (0..NSRC-1).

Ports:
- clock  in  1  — single clock; all state updates on the rising edge.
- clear  in  1  — asynchronous, active-low reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — FIFO not full; a request is accepted on an edge where req_valid && req_ready.
- req_src  in  5  — bus source index:
  - R0..R15 = 0..15, HI = 16, LO = 17, ZHI = 18, ZLO = 19.
  - PC = 20, MDR = 21, INPORT = 22, CSIGN = 23.
- req_dst  in  5  — destination load index, same numbering as req_src.
- bus_out_sel  out  32  — one-hot bus source select; bit i drives source i. All-zero when no transfer is in progress.
- load_en  out  32  — one-hot destination load enable.
- busy  out  1  — (state != IDLE) || FIFO non-empty.
- done  out  1  — one-cycle pulse per completed transfer.
- err  out  1  — one-cycle pulse when an accepted request has an index >= NSRC.

## Operation
- FIFO entry is {src, dst}, 10 bits. The FIFO uses a count register; req_ready = (count != DEPTH), decoded from registered count.
- No push is permitted when full, even if a pop happens in the same cycle.
- Index check on accept:
  - If src >= NSRC or dst >= NSRC, the request is consumed (handshake completes), not queued, and err = 1 in the following cycle.
  - Valid requests are queued.
- FSM states:
  - IDLE: outputs zero. If FIFO non-empty, pop the head and go to DRIVE.
  - DRIVE: bus_out_sel = 1 << src; load_en = 0. Go to LOAD unconditionally.
  - LOAD: bus_out_sel unchanged; load_en = 1 << dst. The destination captures on the edge that ends LOAD.
    - If FIFO non-empty at that edge: pop and go to DRIVE.
    - Otherwise go to IDLE.
- done = 1 for the single cycle after each LOAD.
- bus_out_sel, load_en, done and err are registered; at most one bit of each one-hot vector is ever set.
- src == dst is legal and handled as a normal transfer.
- Simultaneous push and pop on the same edge: count is unchanged; the pushed entry lands behind the popped one.
- Push into an empty FIFO while the FSM is in LOAD: the pop happens at the same edge only if the FIFO was already non-empty before that edge. A new push is popped no earlier than the next edge.
- Reset (clear low, any time, including mid-DRIVE/LOAD):
  - FIFO emptied, count = 0, state = IDLE.
  - bus_out_sel = 0, load_en = 0, done = 0, err = 0, busy = 0, req_ready = 1, all immediately (asynchronous).
  - The in-flight transfer is dropped: no done pulse and no partial load pulse.

## Timing
- Request accepted at edge k into an empty FIFO with the FSM in IDLE:
  - Popped at edge k+1.
  - bus_out_sel valid from k+1 to k+3.
  - load_en valid from k+2 to k+3.
  - Destination latches at edge k+3.
  - done high from k+3 to k+4.
- Latency from accept to capture: 3 edges.
- Sustained throughput: one transfer per 2 cycles, with bus_out_sel changing directly from one source to the next (no idle cycle).
- err is high for the cycle following the accept edge.
- busy deasserts the cycle after the final LOAD if the FIFO is empty.

## Test plan
- Single transfer, src=3 (R3), dst=7 (R7), accepted at edge 1:
  - bus_out_sel = 0x00000008 for cycles 2–3.
  - load_en = 0x00000080 in cycle 3 only.
  - done in cycle 4; all outputs zero and busy = 0 in cycle 5.
- Three back-to-back requests (21→4, 20→17, 23→0):
  - Transfers complete in order, one every 2 cycles.
  - bus_out_sel sequence: 0x00200000, 0x00100000, 0x00800000.
  - load_en sequence: 0x10, 0x20000, 0x1; exactly 3 done pulses.
- Push on every cycle for 8 cycles with DEPTH=4:
  - req_ready drops when count reaches 4.
  - No accepted request is lost or reordered.
  - Total done pulses equal the number of accepted requests.
- Invalid index: src=24, dst=2:
  - Accepted, err pulses once the next cycle.
  - No bus_out_sel or load_en activity; a following valid request executes normally.
- clear asserted mid-LOAD with 2 requests queued:
  - Outputs zero immediately; no done; FIFO empty; req_ready = 1.
  - After release, a new request 0→1 completes with the standard 3-edge latency.
